// File: rtl/rank_change_reporter.sv
// Reports every change of the monitored value as a {value, timestamp} event through a small FIFO.
// Optional RANK_CHANGE_DROP_CNT_EN adds a saturating 16-bit count of dropped events on drop_cnt.
module rank_change_reporter #(
  parameter int DATA_WIDTH = 32,
  parameter int TS_WIDTH   = 16,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic                  overflow
`ifdef RANK_CHANGE_DROP_CNT_EN
  ,
  output logic [15:0]           drop_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] prev;
  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [TS_WIDTH-1:0]   ts_mem   [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  logic change;
  logic pop;
  logic full;
  logic push;
  logic drop;

  assign change = (din != prev);
  assign pop    = out_valid & out_ready;
  assign full   = (count == CW'(DEPTH));
  // A pop in the same cycle frees the slot the push needs.
  assign push   = change & (~full | pop);
  assign drop   = change & full & ~pop;

  assign out_valid = (count != '0);
  assign out_data  = data_mem[rd_ptr];
  assign out_ts    = ts_mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      prev     <= '0;
      ts       <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        ts_mem[i]   <= '0;
      end
    end else begin
      prev <= din;
      ts   <= ts + 1'b1;
      if (push) begin
        data_mem[wr_ptr] <= din;
        ts_mem[wr_ptr]   <= ts;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef RANK_CHANGE_DROP_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      drop_cnt <= '0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rank_change_reporter.sv
// Directed bench for rank_change_reporter: single event, backpressure/drop, full-with-pop,
// timestamp wrap (TS_WIDTH=4), mid-operation reset and repeated values.
module tb_rank_change_reporter;
  localparam int DW = 32;
  localparam int TW = 4;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [DW-1:0] din = '0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [TW-1:0] out_ts;
  logic          overflow;
`ifdef RANK_CHANGE_DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  rank_change_reporter #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .DEPTH(D)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ts    (out_ts),
    .overflow  (overflow)
`ifdef RANK_CHANGE_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (timestamp 0) just after release.
  task automatic do_reset;
    resetn = 1'b0;
    din = '0;
    out_ready = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  initial begin
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ts", out_ts, 0);
    check("rst_ovf", overflow, 0);

    // Single event: 5 appears in cycle 3
    do_reset();
    out_ready = 1'b1;
    repeat (3) tick();
    din = 5;
    tick();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 5);
    check("single_ts", out_ts, 3);
    tick();
    check("single_popped", out_valid, 0);
    repeat (3) tick();
    check("single_only_one", out_valid, 0);

    // Backpressure: 1..5, fifth dropped
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      din = i;
      tick();
    end
    check("bp_ovf", overflow, 1);
    check("bp_valid", out_valid, 1);
    check("bp_head", out_data, 1);
    tick();
    tick();
    check("bp_stable_data", out_data, 1);
    check("bp_stable_ts", out_ts, 0);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_order_data", out_data, i);
      check("bp_order_ts", out_ts, i - 1);
      tick();
    end
    check("bp_empty", out_valid, 0);
    check("bp_ovf_sticky", overflow, 1);
`ifdef RANK_CHANGE_DROP_CNT_EN
    check("bp_drop_cnt", drop_cnt, 1);
`endif

    // Full with simultaneous pop and push
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      din = i;
      tick();
    end
    out_ready = 1'b1;
    din = 9;
    tick();
    check("fp_ovf", overflow, 0);
    for (int i = 2; i <= 4; i++) begin
      check("fp_data", out_data, i);
      check("fp_ts", out_ts, i - 1);
      tick();
    end
    check("fp_new_data", out_data, 9);
    check("fp_new_ts", out_ts, 4);
    tick();
    check("fp_empty", out_valid, 0);
`ifdef RANK_CHANGE_DROP_CNT_EN
    check("fp_drop_cnt", drop_cnt, 0);
`endif

    // Timestamp wrap with 4-bit timestamp
    do_reset();
    out_ready = 1'b1;
    repeat (15) tick();
    din = 1;
    tick();
    check("wrap_data0", out_data, 1);
    check("wrap_ts15", out_ts, 15);
    din = 2;
    tick();
    check("wrap_data1", out_data, 2);
    check("wrap_ts0", out_ts, 0);

    // Reset mid-operation with full FIFO and overflow set
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      din = i;
      tick();
    end
    check("mr_pre_valid", out_valid, 1);
    check("mr_pre_ovf", overflow, 1);
    resetn = 1'b0;
    #1;
    check("mr_valid", out_valid, 0);
    check("mr_ovf", overflow, 0);
    check("mr_data", out_data, 0);
`ifdef RANK_CHANGE_DROP_CNT_EN
    check("mr_drop_cnt", drop_cnt, 0);
`endif
    din = 0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (3) tick();
    check("mr_no_event", out_valid, 0);
    din = 6;
    tick();
    check("mr_resume_valid", out_valid, 1);
    check("mr_resume_data", out_data, 6);

    // Repeated value
    do_reset();
    din = 7;
    repeat (10) tick();
    check("rep_valid", out_valid, 1);
    check("rep_data", out_data, 7);
    check("rep_ts", out_ts, 0);
    out_ready = 1'b1;
    tick();
    check("rep_one_event", out_valid, 0);
    check("rep_ovf", overflow, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
